// File: rtl/multicycle_alu.sv
// Execution unit: single-cycle logic/arith/shift ops plus an iterative shift-add multiplier.
// Result, zero and illegal are registered and qualified by a one-cycle done pulse.
module multicycle_alu #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       operation_code,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSll = 4'b1101;
    localparam logic [3:0] OpMul = 4'b1010;

    localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);
    localparam logic [SHW-1:0] CntOne  = SHW'(1);

    typedef enum logic [1:0] {
        StIdle,
        StMulRun,
        StMulFin
    } state_e;

    state_e           state_q;
    logic [3:0]       op_q;
    logic             pend_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [SHW-1:0]   cnt_q;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;

    // Operands of a single-cycle op share the multiplier's operand registers.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (op_q)
            OpAnd:   alu_res = mcand_q & mplier_q;
            OpOr:    alu_res = mcand_q | mplier_q;
            OpAdd:   alu_res = mcand_q + mplier_q;
            OpSub:   alu_res = mcand_q - mplier_q;
            OpSll:   alu_res = mcand_q << mplier_q[SHW-1:0];
            default: alu_ill = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            op_q     <= '0;
            pend_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done   <= 1'b0;
            pend_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    // Retire the op captured last edge while possibly accepting the next one.
                    if (pend_q) begin
                        result  <= alu_res;
                        zero    <= (alu_res == '0);
                        illegal <= alu_ill;
                        done    <= 1'b1;
                    end
                    if (start) begin
                        op_q     <= operation_code;
                        mcand_q  <= a;
                        mplier_q <= b;
                        acc_q    <= '0;
                        cnt_q    <= '0;
                        if (operation_code == OpMul) begin
                            state_q <= StMulRun;
                            busy    <= 1'b1;
                        end else begin
                            pend_q <= 1'b1;
                        end
                    end
                end
                StMulRun: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + mcand_q;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntOne;
                    if (cnt_q == CntLast) begin
                        state_q <= StMulFin;
                    end
                end
                StMulFin: begin
                    result  <= acc_q;
                    zero    <= (acc_q == '0);
                    illegal <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: scoreboard of expected completions, checked on each done.
module tb_multicycle_alu;

    localparam int W = 32;
    localparam int S = 5;

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSll = 4'b1101;
    localparam logic [3:0] OpMul = 4'b1010;
    localparam logic [3:0] OpBad = 4'b0101;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   opc;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         il;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int busy_cnt = 0;
    int cyc = 0;
    int last_done_cyc = 0;
    int acc_cyc;
    int d0;
    int b0;

    multicycle_alu #(
        .WIDTH(W),
        .SHW  (S)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .operation_code(opc),
        .a             (a),
        .b             (b),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .zero          (zero),
        .illegal       (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [W-1:0] aa, input logic [W-1:0] bb);
        start = 1'b1;
        opc   = op;
        a     = aa;
        b     = bb;
    endtask

    // Every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            last_done_cyc = cyc;
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow: observed done=1 expected no done");
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("zero", 32'(zero), 32'(e.z));
                chk("illegal", 32'(illegal), 32'(e.il));
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        opc   = '0;
        a     = '0;
        b     = '0;
        tick(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", 32'(zero), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        reset = 1'b0;
        tick(1);

        // ADD with carry out wraps to zero
        d0 = done_cnt;
        b0 = busy_cnt;
        issue(OpAdd, 32'hFFFF_FFFF, 32'd1);
        sb.push_back('{res: 32'h0, z: 1'b1, il: 1'b0});
        tick(1);
        start   = 1'b0;
        acc_cyc = cyc;
        tick(2);
        chk("add_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("add_latency", 32'(last_done_cyc), 32'(acc_cyc + 1));
        chk("add_busy", 32'(busy_cnt - b0), 32'd0);

        // Back-to-back single-cycle ops
        d0 = done_cnt;
        issue(OpSub, 32'd5, 32'd7);
        sb.push_back('{res: 32'hFFFF_FFFE, z: 1'b0, il: 1'b0});
        tick(1);
        issue(OpAnd, 32'h0000_F0F0, 32'h0000_0FF0);
        sb.push_back('{res: 32'h0000_00F0, z: 1'b0, il: 1'b0});
        tick(1);
        issue(OpOr, 32'h1, 32'h2);
        sb.push_back('{res: 32'h3, z: 1'b0, il: 1'b0});
        tick(1);
        issue(OpSll, 32'h1, 32'h25);
        sb.push_back('{res: 32'h20, z: 1'b0, il: 1'b0});
        tick(1);
        start   = 1'b0;
        acc_cyc = cyc;
        tick(3);
        chk("b2b_done_cnt", 32'(done_cnt - d0), 32'd4);
        chk("b2b_last_latency", 32'(last_done_cyc), 32'(acc_cyc + 1));

        // MUL -3 * 7 with start held and inputs changing while busy
        d0 = done_cnt;
        b0 = busy_cnt;
        issue(OpMul, 32'hFFFF_FFFD, 32'd7);
        sb.push_back('{res: 32'hFFFF_FFEB, z: 1'b0, il: 1'b0});
        tick(1);
        acc_cyc = cyc;
        opc = OpAdd;
        a   = $urandom;
        b   = $urandom;
        tick(W);
        chk("mul_busy_before_done", 32'(busy), 32'd1);
        tick(1);
        start = 1'b0;
        tick(3);
        chk("mul_done_cnt", 32'(done_cnt - d0), 32'd1);
        chk("mul_latency", 32'(last_done_cyc), 32'(acc_cyc + W + 1));
        chk("mul_busy_cycles", 32'(busy_cnt - b0), 32'(W + 1));

        // MUL overflowing to zero, then an undefined op
        d0 = done_cnt;
        b0 = busy_cnt;
        issue(OpMul, 32'h0001_0000, 32'h0001_0000);
        sb.push_back('{res: 32'h0, z: 1'b1, il: 1'b0});
        tick(1);
        start = 1'b0;
        tick(W + 3);
        chk("mul0_busy_cycles", 32'(busy_cnt - b0), 32'(W + 1));
        issue(OpBad, 32'd7, 32'd9);
        sb.push_back('{res: 32'h0, z: 1'b1, il: 1'b1});
        tick(1);
        start   = 1'b0;
        acc_cyc = cyc;
        tick(2);
        chk("ill_done_cnt", 32'(done_cnt - d0), 32'd2);
        chk("ill_latency", 32'(last_done_cyc), 32'(acc_cyc + 1));

        // Reset aborts an in-flight MUL
        issue(OpAdd, 32'd5, 32'd6);
        sb.push_back('{res: 32'd11, z: 1'b0, il: 1'b0});
        tick(1);
        start = 1'b0;
        tick(2);
        chk("pre_rst_result", result, 32'd11);
        issue(OpMul, 32'd3, 32'd4);
        tick(1);
        start = 1'b0;
        tick(9);
        chk("abort_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_result", result, 32'd0);
        tick(2);
        reset = 1'b0;
        d0 = done_cnt;
        tick(W + 4);
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        issue(OpAdd, 32'd2, 32'd2);
        sb.push_back('{res: 32'd4, z: 1'b0, il: 1'b0});
        tick(1);
        start   = 1'b0;
        acc_cyc = cyc;
        tick(2);
        chk("post_rst_latency", 32'(last_done_cyc), 32'(acc_cyc + 1));
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
